fwd_select_ctrl: RTL and testbench

Forwarding and hazard control unit for the 8-bit pipelined core. It tracks the destination registers of in-flight instructions in the EX, MEM and WB stages and drives the 2-bit operand-source select codes consumed by the EX-stage operand multiplexers. It also raises a load-use stall toward the fetch/decode stages. It sits beside the ID/EX pipeline register; its select outputs are registered so they are valid when the instruction enters EX.

---
 rtl/fwd_select_ctrl.sv | 115 +++++++++++
 tb/tb_fwd_select_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_select_ctrl.sv
// Forwarding-select and load-use stall control for the 8-bit pipelined core.
// Define FWD_WB_EN to forward the WB-stage result (code 10); otherwise a MEM-slot hit stalls instead.
module fwd_select_ctrl #(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic              load;
        logic [REG_AW-1:0] rd;
    } ex_slot_t;

    // The load flag only matters while the producer sits in EX, so later slots drop it.
    typedef struct packed {
        logic              valid;
        logic              we;
        logic [REG_AW-1:0] rd;
    } prod_slot_t;

    typedef struct packed {
        logic [1:0] sel;
        logic       stall;
    } hazard_t;

    ex_slot_t   ex_q;
    prod_slot_t mem_q;
    prod_slot_t wb_q;
    hazard_t    hz_a;
    hazard_t    hz_b;

    function automatic logic produces(input logic valid, input logic we,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
        return valid && we && (rd == rs);
    endfunction

    function automatic hazard_t eval_src(input logic              active,
                                         input logic [REG_AW-1:0] rs,
                                         input ex_slot_t          ex,
                                         input prod_slot_t        mem,
                                         input prod_slot_t        wb);
        hazard_t r;
        r.sel   = SEL_RF;
        r.stall = 1'b0;
        if (!active) begin
            r.sel = SEL_RF;
        end else if (produces(ex.valid, ex.we, ex.rd, rs)) begin
            if (ex.load) r.stall = 1'b1;
            else         r.sel   = SEL_MEM;
        end else if (produces(mem.valid, mem.we, mem.rd, rs)) begin
`ifdef FWD_WB_EN
            r.sel = SEL_WB;
`else
            r.stall = 1'b1;
`endif
        end else if (produces(wb.valid, wb.we, wb.rd, rs)) begin
            // Register file is write-first, so a WB producer is already visible there.
            r.sel = SEL_RF;
        end
        return r;
    endfunction

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        hz_a  = '0;
        hz_b  = '0;
        hz_a  = eval_src(id_valid && id_rs1_used, id_rs1, ex_q, mem_q, wb_q);
        hz_b  = eval_src(id_valid && id_rs2_used, id_rs2, ex_q, mem_q, wb_q);
        stall = hz_a.stall || hz_b.stall;
    end

    // NOTE: state is updated with non-blocking assignments so every slot shifts on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_a <= SEL_RF;
            fwd_b <= SEL_RF;
        end else begin
            mem_q <= '{valid: ex_q.valid, we: ex_q.we, rd: ex_q.rd};
            wb_q  <= mem_q;
            if (flush || stall) begin
                ex_q  <= '0;
                fwd_a <= SEL_RF;
                fwd_b <= SEL_RF;
            end else begin
                ex_q  <= '{valid: id_valid, we: id_we, load: id_is_load, rd: id_rd};
                fwd_a <= hz_a.sel;
                fwd_b <= hz_b.sel;
            end
        end
    end

endmodule

// File: tb/tb_fwd_select_ctrl.sv
// Scoreboard bench for fwd_select_ctrl: expected select codes are queued at issue and
// compared one cycle later; stall is compared in the issuing cycle.
module tb_fwd_select_ctrl;

`ifdef FWD_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [1:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
    logic [1:0] fwd_a, fwd_b;
    logic       stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t sb[$];

    fwd_select_ctrl #(.REG_AW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_we       (id_we),
        .id_is_load  (id_is_load),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Select codes appear one edge after issue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (fwd_a !== e.a || fwd_b !== e.b) begin
                errors++;
                $display("FAIL %s fwd_a/fwd_b got %b/%b expected %b/%b", e.tag, fwd_a, fwd_b, e.a, e.b);
            end
        end
    end

    task automatic issue(input string tag, input bit v, input logic [1:0] rd, input bit we, input bit ld,
                         input logic [1:0] rs1, input bit u1, input logic [1:0] rs2, input bit u2,
                         input bit fl, input bit exp_stall, input logic [1:0] ea, input logic [1:0] eb);
        exp_t e;
        @(negedge clk);
        id_valid    = v;
        id_rd       = rd;
        id_we       = we;
        id_is_load  = ld;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        flush       = fl;
        #1;
        checks++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL %s stall got %b expected %b", tag, stall, exp_stall);
        end
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        sb.push_back(e);
    endtask

    task automatic alu(input string tag, input logic [1:0] rd, input logic [1:0] rs1, input logic [1:0] rs2,
                       input bit exp_stall, input logic [1:0] ea, input logic [1:0] eb);
        issue(tag, 1'b1, rd, 1'b1, 1'b0, rs1, 1'b1, rs2, 1'b1, 1'b0, exp_stall, ea, eb);
    endtask

    task automatic load(input string tag, input logic [1:0] rd, input logic [1:0] rs1);
        issue(tag, 1'b1, rd, 1'b1, 1'b1, rs1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 3; i++)
            issue("nop", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_init fwd_a/fwd_b/stall got %b/%b/%b expected 00/00/0", fwd_a, fwd_b, stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_slots();
        alu("rst_prod", 2'd1, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        issue("rst_ld", 1'b1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        // Present a load-use consumer, then reset while fwd_a is still 01.
        @(negedge clk);
        id_valid = 1'b1; id_rd = 2'd3; id_we = 1'b1; id_is_load = 1'b0;
        id_rs1 = 2'd2; id_rs1_used = 1'b1; id_rs2 = 2'd2; id_rs2_used = 1'b1; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_stall stall got %b expected 1", stall);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async fwd_a/fwd_b/stall got %b/%b/%b expected 00/00/0", fwd_a, fwd_b, stall);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        alu("rst_first", 2'd3, 2'd2, 2'd2, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_alu_chain();
        clear_slots();
        alu("chain0", 2'd1, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("chain1", 2'd2, 2'd1, 2'd1, 1'b0, 2'b01, 2'b01);
        issue("chain_unused", 1'b1, 2'd3, 1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00);
        issue("chain_invalid", 1'b0, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        alu("chain_d2", 2'd0, 2'd3, 2'd1, !WB, WB ? 2'b10 : 2'b00, 2'b00);
        if (!WB) alu("chain_d2_after", 2'd0, 2'd3, 2'd1, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_distance();
        clear_slots();
        alu("d2_prod", 2'd3, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("d2_indep", 2'd2, 2'd1, 2'd1, 1'b0, 2'b00, 2'b00);
        issue("d2", 1'b1, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, !WB, WB ? 2'b10 : 2'b00, 2'b00);
        if (!WB) issue("d2_after", 1'b1, 2'd1, 1'b1, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        clear_slots();
        alu("d3_prod", 2'd3, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("d3_i1", 2'd2, 2'd1, 2'd1, 1'b0, 2'b00, 2'b00);
        alu("d3_i2", 2'd1, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("d3", 2'd0, 2'd3, 2'd3, 1'b0, 2'b00, 2'b00);
        clear_slots();
        load("l2_ld", 2'd2, 2'd0);
        alu("l2_indep", 2'd1, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("l2", 2'd3, 2'd0, 2'd2, !WB, 2'b00, WB ? 2'b10 : 2'b00);
        if (!WB) alu("l2_after", 2'd3, 2'd0, 2'd2, 1'b0, 2'b00, 2'b00);
    endtask

    task automatic test_load_use();
        clear_slots();
        load("lu_ld", 2'd2, 2'd0);
        alu("lu_stall", 2'd3, 2'd0, 2'd2, 1'b1, 2'b00, 2'b00);
        alu("lu_fwd", 2'd3, 2'd0, 2'd2, !WB, 2'b00, WB ? 2'b10 : 2'b00);
        if (!WB) alu("lu_after", 2'd3, 2'd0, 2'd2, 1'b0, 2'b00, 2'b00);
        alu("lu_next", 2'd0, 2'd3, 2'd3, 1'b0, 2'b01, 2'b01);
    endtask

    task automatic test_priority();
        clear_slots();
        alu("pr_old", 2'd1, 2'd0, 2'd0, 1'b0, 2'b00, 2'b00);
        alu("pr_young", 2'd1, 2'd2, 2'd2, 1'b0, 2'b00, 2'b00);
        alu("pr_use", 2'd3, 2'd1, 2'd1, 1'b0, 2'b01, 2'b01);
    endtask

    task automatic test_flush();
        clear_slots();
        load("fl_ld", 2'd2, 2'd0);
        issue("fl_stall", 1'b1, 2'd3, 1'b1, 1'b0, 2'd2, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00);
        alu("fl_next", 2'd0, 2'd3, 2'd1, 1'b0, 2'b00, 2'b00);
        issue("fl_zero", 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        alu("fl_after", 2'd2, 2'd1, 2'd1, 1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
        id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0; flush = 1'b0;
        test_reset();
        test_alu_chain();
        test_distance();
        test_load_use();
        test_priority();
        test_flush();
        clear_slots();
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending entries got %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
